// File: rtl/button_encoder_pkg.sv
// Shared types, sizes and helpers for the front-panel button encoder.
//   state_e    : encoder FSM states
//   NUM_BTN    : number of one-hot buttons
//   CODE_W     : width of the encoded button index
//   encode     : one-hot pattern -> index (0 for non-one-hot input)
//   is_onehot  : true when exactly one bit is set
package button_encoder_pkg;

  localparam int unsigned NUM_BTN = 4;
  localparam int unsigned CODE_W  = 2;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StDebounce = 2'd1,
    StHeld     = 2'd2,
    StRelease  = 2'd3
  } state_e;

  function automatic logic [CODE_W-1:0] encode(logic [NUM_BTN-1:0] onehot);
    logic [CODE_W-1:0] idx;
    case (onehot)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic is_onehot(logic [NUM_BTN-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/button_encoder_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
// Ports:
//   clk : sampling clock
//   rst : asynchronous active-high reset, clears both stages
//   d   : asynchronous input levels
//   q   : synchronised levels (two clk edges of latency)
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage1_q;
  logic [WIDTH-1:0] stage2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      stage1_q <= d;
      stage2_q <= stage1_q;
    end
  end

  assign q = stage2_q;

endmodule

// File: rtl/button_encoder.sv
// Front-panel button encoder: synchronises four one-hot buttons, debounces
// press and release, issues a 2-bit index with a one-cycle valid strobe and
// flags multi-button presses with a one-cycle error strobe.
// Optional feature macro: BUTTON_ENCODER_REPEAT_EN enables auto-repeat of
// code_valid every REPEAT_CYCLES while a single button stays held.
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   btn_in     : raw asynchronous button levels, bit i = index i
//   code       : index of the last accepted single press
//   code_valid : one-cycle pulse when code is (re)issued
//   multi_err  : one-cycle pulse when a debounced multi-hot pattern is rejected
//   busy       : high whenever the FSM is not idle
module button_encoder
  import button_encoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_CYCLES   = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  output logic              multi_err,
  output logic              busy
);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
    $error("button_encoder: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] sync;

  sync_2ff #(
    .WIDTH (NUM_BTN)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (sync)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_BTN-1:0] cap_q, cap_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic               code_valid_q, code_valid_d;
  logic               multi_err_q, multi_err_d;
  logic               busy_q, busy_d;

`ifdef BUTTON_ENCODER_REPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cap_d        = cap_q;
    code_d       = code_q;
    code_valid_d = 1'b0;
    multi_err_d  = 1'b0;
`ifdef BUTTON_ENCODER_REPEAT_EN
    rpt_d        = rpt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (sync != '0) begin
          cap_d   = sync;
          cnt_d   = '0;
          state_d = StDebounce;
        end
      end

      StDebounce: begin
        if (sync != cap_q) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == CNT_MAX) begin
          if (is_onehot(cap_q)) begin
            code_d       = encode(cap_q);
            code_valid_d = 1'b1;
          end else begin
            multi_err_d  = 1'b1;
          end
          state_d = StHeld;
`ifdef BUTTON_ENCODER_REPEAT_EN
          rpt_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StHeld: begin
        // Other nonzero patterns are ignored until a full release.
        if (sync == '0) begin
          cnt_d   = '0;
          state_d = StRelease;
        end
`ifdef BUTTON_ENCODER_REPEAT_EN
        else if (rpt_q == RPT_MAX) begin
          rpt_d = '0;
          // Repeat only a press that produced a code, never an error.
          code_valid_d = is_onehot(cap_q);
        end else begin
          rpt_d = rpt_q + 1'b1;
        end
`endif
      end

      StRelease: begin
        if (sync != '0) begin
          state_d = StHeld;
`ifdef BUTTON_ENCODER_REPEAT_EN
          rpt_d   = '0;
`endif
        end else if (cnt_q == CNT_MAX) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      cap_q        <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      multi_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cap_q        <= cap_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      multi_err_q  <= multi_err_d;
      busy_q       <= busy_d;
    end
  end

`ifdef BUTTON_ENCODER_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_d;
    end
  end
`endif

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign multi_err  = multi_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_button_encoder.sv
// Directed self-checking bench for button_encoder (DEBOUNCE_CYCLES=4,
// REPEAT_CYCLES=8). Inputs change 1 time unit after a rising edge; outputs are
// sampled at the same point, so loop index i is the edge just taken.
module tb_button_encoder;

`ifdef BUTTON_ENCODER_REPEAT_EN
  localparam bit RptEn = 1'b1;
`else
  localparam bit RptEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_in;
  logic [1:0] code;
  logic       code_valid;
  logic       multi_err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  button_encoder #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_CYCLES   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .code       (code),
    .code_valid (code_valid),
    .multi_err  (multi_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Valid expected at edge 7 of a press, plus every 8 edges while held when
  // auto-repeat is built in.
  function automatic logic exp_valid(int i);
    if (i == 7) return 1'b1;
    if (RptEn && i > 7 && ((i - 7) % 8) == 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    btn_in = 4'b0000;
    #1;
    step();
    step();
    checks++; if (code !== 2'b00) begin errors++; $display("FAIL reset_code got %b want 00", code); end
    checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", code_valid); end
    checks++; if (multi_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", multi_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", code_valid); end
  endtask

  task automatic test_clean_press();
    btn_in = 4'b0010;
    for (int i = 1; i <= 20; i++) begin
      step();
      checks++;
      if (code_valid !== exp_valid(i)) begin
        errors++; $display("FAIL clean_valid edge %0d got %b want %b", i, code_valid, exp_valid(i));
      end
      checks++;
      if (busy !== (i >= 3)) begin
        errors++; $display("FAIL clean_busy edge %0d got %b want %b", i, busy, (i >= 3));
      end
      if (i == 7) begin
        checks++; if (code !== 2'b01) begin errors++; $display("FAIL clean_code got %b want 01", code); end
      end
    end
    btn_in = 4'b0000;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (code_valid !== 1'b0) begin
        errors++; $display("FAIL clean_release_valid edge %0d got %b want 0", i, code_valid);
      end
      checks++;
      if (busy !== (i < 7)) begin
        errors++; $display("FAIL clean_release_busy edge %0d got %b want %b", i, busy, (i < 7));
      end
    end
  endtask

  task automatic test_reset_mid();
    btn_in = 4'b0100;
    for (int i = 0; i < 4; i++) step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre got %b want 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (code !== 2'b00) begin errors++; $display("FAIL mid_code got %b want 00", code); end
    checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", code_valid); end
    checks++; if (multi_err !== 1'b0) begin errors++; $display("FAIL mid_err got %b want 0", multi_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
    step();
    step();
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (code_valid !== (i == 7)) begin
        errors++; $display("FAIL mid_valid edge %0d got %b want %b", i, code_valid, (i == 7));
      end
      if (i == 7) begin
        checks++; if (code !== 2'b10) begin errors++; $display("FAIL mid_code_after got %b want 10", code); end
      end
    end
    btn_in = 4'b0000;
    for (int i = 0; i < 12; i++) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_release_busy got %b want 0", busy); end
  endtask

  task automatic test_press_glitch();
    btn_in = 4'b1000;
    step();
    step();
    btn_in = 4'b0000;
    for (int i = 1; i <= 12; i++) begin
      step();
      checks++;
      if (code_valid !== 1'b0 || multi_err !== 1'b0) begin
        errors++; $display("FAIL glitch_out edge %0d got %b%b want 00", i, code_valid, multi_err);
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b want 0", busy); end
    checks++; if (code !== 2'b10) begin errors++; $display("FAIL glitch_code got %b want 10", code); end
  endtask

  task automatic test_release_bounce();
    btn_in = 4'b1000;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (code_valid !== (i == 7)) begin
        errors++; $display("FAIL bounce_press_valid edge %0d got %b want %b", i, code_valid, (i == 7));
      end
      if (i == 7) begin
        checks++; if (code !== 2'b11) begin errors++; $display("FAIL bounce_code got %b want 11", code); end
      end
    end
    btn_in = 4'b0000;
    step();
    btn_in = 4'b1000;
    step();
    btn_in = 4'b0000;
    for (int i = 1; i <= 15; i++) begin
      step();
      checks++;
      if (code_valid !== 1'b0) begin
        errors++; $display("FAIL bounce_release_valid edge %0d got %b want 0", i, code_valid);
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bounce_busy got %b want 0", busy); end
  endtask

  task automatic test_multi();
    btn_in = 4'b0011;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (multi_err !== (i == 7)) begin
        errors++; $display("FAIL multi_err edge %0d got %b want %b", i, multi_err, (i == 7));
      end
      checks++;
      if (code_valid !== 1'b0) begin
        errors++; $display("FAIL multi_valid edge %0d got %b want 0", i, code_valid);
      end
    end
    checks++; if (code !== 2'b11) begin errors++; $display("FAIL multi_code got %b want 11", code); end
    btn_in = 4'b0000;
    for (int i = 0; i < 12; i++) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multi_busy got %b want 0", busy); end
  endtask

  task automatic test_held_change();
    btn_in = 4'b0001;
    for (int i = 1; i <= 20; i++) begin
      if (i == 11) btn_in = 4'b0100;
      step();
      checks++;
      if (code_valid !== exp_valid(i)) begin
        errors++; $display("FAIL held_valid edge %0d got %b want %b", i, code_valid, exp_valid(i));
      end
      if (i == 7 || i == 20) begin
        checks++; if (code !== 2'b00) begin errors++; $display("FAIL held_code edge %0d got %b want 00", i, code); end
      end
    end
    btn_in = 4'b0000;
    for (int i = 0; i < 12; i++) step();
    btn_in = 4'b0100;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (code_valid !== (i == 7)) begin
        errors++; $display("FAIL held_repress_valid edge %0d got %b want %b", i, code_valid, (i == 7));
      end
    end
    checks++; if (code !== 2'b10) begin errors++; $display("FAIL held_repress_code got %b want 10", code); end
    btn_in = 4'b0000;
    for (int i = 0; i < 12; i++) step();
  endtask

  task automatic test_repeat();
    btn_in = 4'b0001;
    for (int i = 1; i <= 30; i++) begin
      step();
      checks++;
      if (code_valid !== exp_valid(i)) begin
        errors++; $display("FAIL repeat_valid edge %0d got %b want %b", i, code_valid, exp_valid(i));
      end
      if (exp_valid(i)) begin
        checks++; if (code !== 2'b00) begin errors++; $display("FAIL repeat_code edge %0d got %b want 00", i, code); end
      end
    end
    btn_in = 4'b0000;
    for (int i = 0; i < 12; i++) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL repeat_busy got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_reset_mid();
    test_press_glitch();
    test_release_bounce();
    test_multi();
    test_held_change();
    test_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_encoder.md
Name: button_encoder

Overview:
- Reverse direction of the digit-select one-hot decoder: takes four one-hot front-panel buttons and produces a 2-bit index plus a one-cycle valid strobe.
- Synchronises the buttons, debounces press and release, rejects multi-button presses with an error strobe, and holds the last valid code.
- Feeds the clock's set/mode control logic.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles a pattern must be stable to be accepted (10 ms at 100 MHz); legal minimum 2.
- REPEAT_CYCLES, 50000000, auto-repeat period while held. Used only with the optional feature.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn_in  input  4  raw asynchronous button levels; bit i pressed means index i.
- code  output  2  index of the last accepted single press; reset 2'b00.
- code_valid  output  1  one-cycle pulse when code is (re)issued; reset 0.
- multi_err  output  1  one-cycle pulse when a debounced multi-hot pattern is rejected; reset 0.
- busy  output  1  high whenever the FSM is not in IDLE; reset 0.

Behaviour:
- Synchroniser: 2-flop synchroniser per bit. Both stages reset to 0. Its output is called sync.
- Counter: cnt is $clog2(DEBOUNCE_CYCLES) bits wide and reset to 0. It saturates and never wraps.
- Captured pattern: cap[3:0] is reset to 0.
- All outputs are registered. The FSM resets to IDLE.
- IDLE:
  - sync != 0: load cap <= sync, clear cnt, go to DEBOUNCE.
  - Otherwise stay in IDLE.
- DEBOUNCE:
  - sync != cap: go to IDLE and clear cnt. No output.
  - cnt == DEBOUNCE_CYCLES-1 and cap is one-hot: code <= encode(cap), code_valid pulse, go to HELD.
  - cnt == DEBOUNCE_CYCLES-1 and cap is not one-hot: multi_err pulse, code unchanged, go to HELD.
  - Otherwise increment cnt.
- HELD:
  - sync == 0: clear cnt, go to RELEASE.
  - Changes to any other nonzero pattern are ignored. No re-evaluation happens until release.
- RELEASE:
  - sync != 0: go back to HELD. Bounce on release never re-triggers.
  - cnt == DEBOUNCE_CYCLES-1: go to IDLE.
  - Otherwise increment cnt.
- Encode: 0001→00, 0010→01, 0100→10, 1000→11.
- Latency: count edge 1 as the first edge that samples a stable new btn_in. code and code_valid update on edge DEBOUNCE_CYCLES+3, and code_valid is high for exactly that one cycle.
- code_valid and multi_err are never high in the same cycle.
- Reset mid-operation: all state, outputs and the synchroniser clear immediately. A button still held after reset release is treated as a new press and takes the full debounce.
- Input glitches shorter than DEBOUNCE_CYCLES produce no output in either direction.

Optional Feature:
- Macro: BUTTON_ENCODER_REPEAT_EN.
- Defined:
  - HELD runs a second counter, rpt, cleared on entry to HELD.
  - Each time rpt reaches REPEAT_CYCLES-1, rpt clears and code_valid pulses again with the same code.
  - Repeat applies only if the accepted pattern was one-hot. multi_err never repeats.
- Undefined: the rpt logic is absent, and exactly one code_valid is issued per debounced press.

Decomposition:
- Package button_encoder_pkg holds:
  - the state enum (IDLE, DEBOUNCE, HELD, RELEASE, 2-bit encoding);
  - NUM_BTN = 4 and CODE_W = 2;
  - the onehot-to-index encode function.
- Sub-module sync_2ff: parameterised-width 2-flop synchroniser with asynchronous active-high reset, instantiated once for btn_in.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8):
- Reset check: assert rst mid-DEBOUNCE with btn_in=0100 → outputs 0/0/0/00 immediately. Keep btn_in held through rst release → code=10 and code_valid appear 7 edges after rst deasserts.
- Clean press: btn_in=0010 held 20 cycles, then 0 → code=01 and code_valid high for the single cycle after edge 7, busy high until RELEASE completes, no second pulse.
- Bounce rejection:
  - btn_in=1000 held 2 cycles, then 0 → no code_valid, busy returns to 0, code keeps its old value.
  - Release bounce of 0/1000/0 at 1-cycle intervals → no extra pulse.
- Multi-press: btn_in=0011 stable 10 cycles → multi_err single pulse at edge 7, code unchanged, no code_valid.
- Held-pattern change: press 0001 (code=00 issued), then switch to 0100 while held → no new pulse. Release then press 0100 → code=10.
- Repeat, macro on: hold 0001 for 30 cycles → code_valid at edge 7, then every 8 cycles (edges 15 and 23). Macro off → single pulse only.
